// File: rtl/dac_pattern_gen.sv
// RGB test-pattern source for bring-up of the resistor-ladder video DAC.
// Registered channel codes advance once every DIV_COUNT clocks; step/frame strobes trigger the scope.
module dac_pattern_gen #(
  parameter int CH_WIDTH  = 2,
  parameter int DIV_COUNT = 10000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  pause,
  input  logic                  triangle,
  input  logic [3*CH_WIDTH-1:0] hold_val,
  output logic [CH_WIDTH-1:0]   r,
  output logic [CH_WIDTH-1:0]   g,
  output logic [CH_WIDTH-1:0]   b,
  output logic                  step,
  output logic                  frame
);

  localparam int                  DIV_W    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [CH_WIDTH-1:0] MAX      = {CH_WIDTH{1'b1}};

  typedef enum logic [1:0] {M_GRAY = 2'd0, M_SWEEP = 2'd1, M_BARS = 2'd2, M_HOLD = 2'd3} mode_e;
  typedef enum logic [1:0] {CH_R = 2'd0, CH_G = 2'd1, CH_B = 2'd2} chan_e;

  // One ramp step; returns {done, dir_down, level}. done marks a completed ramp period.
  // Out-of-range starts (left behind by a saw/tri switch) turn around instead of wrapping.
  function automatic logic [CH_WIDTH+1:0] ramp_step(input logic [CH_WIDTH-1:0] lvl,
                                                    input logic down, input logic tri_en);
    logic [CH_WIDTH-1:0] nl;
    logic                nd;
    logic                done;
    nl   = lvl + 1'b1;
    nd   = down;
    done = 1'b0;
    if (!tri_en) begin
      done = (lvl == MAX);
    end else if (!down) begin
      if (lvl == MAX) begin
        nl = lvl - 1'b1;
        nd = 1'b1;
      end else if (nl == MAX) begin
        nd = 1'b1;
      end
    end else begin
      if (lvl == '0) begin
        nd = 1'b0;
      end else begin
        nl = lvl - 1'b1;
        if (nl == '0) begin
          nd   = 1'b0;
          done = 1'b1;
        end
      end
    end
    return {done, nd, nl};
  endfunction

  logic [DIV_W-1:0]    div_q, div_d;
  logic [CH_WIDTH-1:0] level_q, level_d;
  logic                dir_q, dir_d;
  chan_e               chan_q, chan_d;
  logic [2:0]          bar_q, bar_d;
  mode_e               mode_q, mode_d;
  logic [CH_WIDTH-1:0] r_d, g_d, b_d;
  logic                step_d, frame_d;
  logic                mode_chg, adv;
  logic [CH_WIDTH+1:0] ramp;

  assign mode_chg = (mode != mode_q);
  assign adv      = (div_q == DIV_LAST) && !pause && (mode_q != M_HOLD);
  assign ramp     = ramp_step(level_q, dir_q, triangle);

  always_comb begin
    div_d   = div_q;
    level_d = level_q;
    dir_d   = dir_q;
    chan_d  = chan_q;
    bar_d   = bar_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
    frame_d = 1'b0;
    if (mode_chg) begin
      mode_d  = mode_e'(mode);
      div_d   = '0;
      level_d = '0;
      dir_d   = 1'b0;
      chan_d  = CH_R;
      bar_d   = '0;
    end else if (mode_q == M_HOLD) begin
      div_d = '0;
    end else if (!pause) begin
      if (adv) begin
        div_d  = '0;
        step_d = 1'b1;
        case (mode_q)
          M_GRAY: begin
            level_d = ramp[CH_WIDTH-1:0];
            dir_d   = ramp[CH_WIDTH];
            frame_d = ramp[CH_WIDTH+1];
          end
          M_SWEEP: begin
            level_d = ramp[CH_WIDTH-1:0];
            dir_d   = ramp[CH_WIDTH];
            if (ramp[CH_WIDTH+1]) begin
              frame_d = (chan_q == CH_B);
              case (chan_q)
                CH_R:    chan_d = CH_G;
                CH_G:    chan_d = CH_B;
                default: chan_d = CH_R;
              endcase
            end
          end
          M_BARS: begin
            bar_d   = bar_q + 1'b1;
            frame_d = (bar_q == 3'd7);
          end
          default: ;
        endcase
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // Codes are derived from the next state so they land together with step.
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (mode_d)
      M_GRAY: begin
        r_d = level_d;
        g_d = level_d;
        b_d = level_d;
      end
      M_SWEEP: begin
        case (chan_d)
          CH_R:    r_d = level_d;
          CH_G:    g_d = level_d;
          default: b_d = level_d;
        endcase
      end
      M_BARS: begin
        r_d = bar_d[2] ? MAX : '0;
        g_d = bar_d[1] ? MAX : '0;
        b_d = bar_d[0] ? MAX : '0;
      end
      default: begin
        r_d = hold_val[3*CH_WIDTH-1:2*CH_WIDTH];
        g_d = hold_val[2*CH_WIDTH-1:CH_WIDTH];
        b_d = hold_val[CH_WIDTH-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      level_q <= '0;
      dir_q   <= 1'b0;
      chan_q  <= CH_R;
      bar_q   <= '0;
      mode_q  <= M_GRAY;
      r       <= '0;
      g       <= '0;
      b       <= '0;
      step    <= 1'b0;
      frame   <= 1'b0;
    end else begin
      div_q   <= div_d;
      level_q <= level_d;
      dir_q   <= dir_d;
      chan_q  <= chan_d;
      bar_q   <= bar_d;
      mode_q  <= mode_d;
      r       <= r_d;
      g       <= g_d;
      b       <= b_d;
      step    <= step_d;
      frame   <= frame_d;
    end
  end

endmodule

// File: tb/tb_dac_pattern_gen.sv
// Scoreboard bench for dac_pattern_gen: directed stimulus queues expected codes per clock,
// a monitor pops and compares after each rising edge.
module tb_dac_pattern_gen;

  localparam int W   = 2;
  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, pause, triangle;
  logic [1:0]     mode;
  logic [3*W-1:0] hold_val;
  logic [W-1:0]   r, g, b;
  logic           step, frame;

  logic           rst1_n;
  logic [1:0]     mode1 = 2'd0;
  logic           pause1 = 1'b0, triangle1 = 1'b0;
  logic [3*W-1:0] hold_val1 = '0;
  logic [W-1:0]   r1, g1, b1;
  logic           step1, frame1;

  dac_pattern_gen #(.CH_WIDTH(W), .DIV_COUNT(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause), .triangle(triangle),
    .hold_val(hold_val), .r(r), .g(g), .b(b), .step(step), .frame(frame));

  dac_pattern_gen #(.CH_WIDTH(W), .DIV_COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .mode(mode1), .pause(pause1), .triangle(triangle1),
    .hold_val(hold_val1), .r(r1), .g(g1), .b(b1), .step(step1), .frame(frame1));

  typedef struct {
    logic [3*W+1:0] v;
    string          name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] cur_r, cur_g, cur_b;

  function automatic void check(input string name, input logic [3*W+1:0] act,
                                input logic [3*W+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {r,g,b,step,frame}=%b required %b at %0t", name, act, exp, $time);
    end
  endfunction

  // Push the expectation for the coming rising edge, then move to the next falling edge.
  task automatic tick(input bit sel, input logic [W-1:0] er, eg, eb,
                      input logic es, ef, input string name);
    exp_t e;
    e.v    = {er, eg, eb, es, ef};
    e.name = name;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold_ticks(input int n, input string name);
    for (int i = 0; i < n; i++) tick(1'b0, cur_r, cur_g, cur_b, 1'b0, 1'b0, name);
  endtask

  task automatic adv(input logic [W-1:0] nr, ng, nb, input logic fr, input string name);
    hold_ticks(DIV - 1, name);
    tick(1'b0, nr, ng, nb, 1'b1, fr, name);
    cur_r = nr;
    cur_g = ng;
    cur_b = nb;
  endtask

  task automatic set_cur(input logic [W-1:0] nr, ng, nb);
    cur_r = nr;
    cur_g = ng;
    cur_b = nb;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check(e.name, {r, g, b, step, frame}, e.v);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check(e.name, {r1, g1, b1, step1, frame1}, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0; mode = 2'd0; pause = 1'b0; triangle = 1'b0; hold_val = '0;
    set_cur(0, 0, 0);
    @(negedge clk);
    tick(1'b0, 0, 0, 0, 0, 0, "reset");
    tick(1'b0, 0, 0, 0, 0, 0, "reset");

    rst_n = 1'b1;
    adv(1, 1, 1, 0, "gray saw");
    adv(2, 2, 2, 0, "gray saw");
    adv(3, 3, 3, 0, "gray saw");
    adv(0, 0, 0, 1, "gray saw wrap");
    adv(1, 1, 1, 0, "gray saw");
    hold_ticks(2, "gray saw");

    rst_n = 1'b0;
    #1;
    check("async reset", {r, g, b, step, frame}, '0);
    tick(1'b0, 0, 0, 0, 0, 0, "in reset");
    set_cur(0, 0, 0);
    triangle = 1'b1;
    rst_n = 1'b1;
    adv(1, 1, 1, 0, "gray tri");
    adv(2, 2, 2, 0, "gray tri");
    adv(3, 3, 3, 0, "gray tri");
    adv(2, 2, 2, 0, "gray tri");
    adv(1, 1, 1, 0, "gray tri");
    adv(0, 0, 0, 1, "gray tri frame");
    adv(1, 1, 1, 0, "gray tri");
    adv(2, 2, 2, 0, "gray tri");

    hold_ticks(2, "pre pause");
    pause = 1'b1;
    hold_ticks(10, "paused");
    pause = 1'b0;
    hold_ticks(1, "resume");
    tick(1'b0, 3, 3, 3, 1, 0, "resume step");
    set_cur(3, 3, 3);
    adv(2, 2, 2, 0, "tri down");

    triangle = 1'b0;
    mode = 2'd1;
    tick(1'b0, 0, 0, 0, 0, 0, "sweep start");
    set_cur(0, 0, 0);
    adv(1, 0, 0, 0, "sweep r");
    adv(2, 0, 0, 0, "sweep r");
    adv(3, 0, 0, 0, "sweep r");
    adv(0, 0, 0, 0, "sweep r->g");
    adv(0, 1, 0, 0, "sweep g");
    adv(0, 2, 0, 0, "sweep g");
    adv(0, 3, 0, 0, "sweep g");
    adv(0, 0, 0, 0, "sweep g->b");
    adv(0, 0, 1, 0, "sweep b");
    adv(0, 0, 2, 0, "sweep b");
    adv(0, 0, 3, 0, "sweep b");
    adv(0, 0, 0, 1, "sweep frame");

    hold_ticks(1, "pre bars");
    mode = 2'd2;
    tick(1'b0, 0, 0, 0, 0, 0, "bars start");
    set_cur(0, 0, 0);
    adv(0, 0, 3, 0, "bars 1");
    adv(0, 3, 0, 0, "bars 2");
    adv(0, 3, 3, 0, "bars 3");
    adv(3, 0, 0, 0, "bars 4");
    adv(3, 0, 3, 0, "bars 5");
    adv(3, 3, 0, 0, "bars 6");
    adv(3, 3, 3, 0, "bars 7");
    adv(0, 0, 0, 1, "bars wrap");

    hold_val = 6'b10_01_11;
    mode = 2'd3;
    tick(1'b0, 2, 1, 3, 0, 0, "hold load");
    set_cur(2, 1, 3);
    hold_ticks(4, "hold");
    pause = 1'b1;
    hold_ticks(2, "hold paused");
    hold_val = 6'b01_11_00;
    tick(1'b0, 1, 3, 0, 0, 0, "hold update");
    set_cur(1, 3, 0);
    hold_ticks(1, "hold");

    mode = 2'd0;
    tick(1'b0, 0, 0, 0, 0, 0, "mode change paused");
    set_cur(0, 0, 0);
    hold_ticks(3, "paused gray");
    pause = 1'b0;
    adv(1, 1, 1, 0, "gray after pause");

    tick(1'b1, 0, 0, 0, 0, 0, "div1 reset");
    rst1_n = 1'b1;
    tick(1'b1, 1, 1, 1, 1, 0, "div1 step");
    tick(1'b1, 2, 2, 2, 1, 0, "div1 step");
    tick(1'b1, 3, 3, 3, 1, 0, "div1 step");
    tick(1'b1, 0, 0, 0, 1, 1, "div1 wrap");
    tick(1'b1, 1, 1, 1, 1, 0, "div1 step");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
